pattern_frame_transmitter: RTL and testbench

Serial transmitter that produces frames for the serial pattern recognizer on the link. Each accepted payload word is sent as a sync pattern (default 00110), then the payload MSB-first, then an inter-frame gap of idle '1' bits. Sits upstream of the recognizer and is also used as its stimulus source on the bench. Word-parallel input with a valid/ready handshake; one serial bit out per clock.

---
 rtl/pattern_link_pkg.sv | 28 ++
 rtl/pattern_frame_transmitter_if.sv | 22 ++
 rtl/pattern_frame_transmitter.sv | 152 +++++++++++++++
 tb/tb_pattern_frame_transmitter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pattern_link_pkg.sv
// Shared definitions for the pattern link: transmitter FSM encoding, default
// sync pattern and its width, default payload width, small sizing helper.
// Used by the frame transmitter and, on the receive side, the pattern recognizer.
package pattern_link_pkg;

  // Transmitter frame phases.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2,
    GAP  = 2'd3
  } link_state_e;

  // Default sync pattern, sent MSB first. The recognizer searches for the same value.
  localparam int                SYNC_W       = 5;
  localparam logic [SYNC_W-1:0] SYNC_PATTERN = 5'b00110;

  // Default payload width.
  localparam int DEFAULT_DATA_W = 8;

  // Largest of three phase lengths; sizes the shared bit counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pattern_frame_transmitter_if.sv
// Word-parallel payload handshake into the frame transmitter.
// Signals: in_valid (word offered), in_data (payload word), in_ready (sink can accept).
// master = payload source, slave = transmitter; transfer on in_valid & in_ready at posedge.
interface pattern_frame_transmitter_if #(
  parameter int DATA_W = 8
) ();
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/pattern_frame_transmitter.sv
// Serialises each accepted payload as: sync pattern, payload MSB first, GAP_CYCLES idle '1's.
// Latency: word accepted at edge k drives the first sync bit on ser_out in cycle k+1.
// Backpressure: in_ready only while idle; offers during a frame are held by the source.
// Ports: clk, rst (sync, active high), in_if (slave: in_valid/in_data/in_ready),
//        ser_out (idle 1), tx_active (sync+payload bits on line), frame_done (last gap cycle).
module pattern_frame_transmitter
  import pattern_link_pkg::*;
#(
  parameter int                PAT_W      = SYNC_W,
  parameter logic [PAT_W-1:0]  PATTERN    = SYNC_PATTERN,
  parameter int                DATA_W     = DEFAULT_DATA_W,
  parameter int                GAP_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  pattern_frame_transmitter_if.slave   in_if,
  output logic                         ser_out,
  output logic                         tx_active,
  output logic                         frame_done
);

  localparam int CNT_W = $clog2(max3(PAT_W, DATA_W, GAP_CYCLES) + 1);
  // Sync pattern and payload share one shift register so SYNC and DATA shift identically.
  localparam int SR_W  = PAT_W + DATA_W;

  link_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic              ser_out_q, ser_out_d;
  logic              tx_active_q, tx_active_d;
  logic              frame_done_q, frame_done_d;

  logic accept;
  logic last_sync;
  logic last_data;
  logic last_gap;
  logic pre_last_gap;

  assign in_if.in_ready = (state_q == IDLE);
  assign accept         = in_if.in_valid && (state_q == IDLE);

  assign last_sync    = (cnt_q == CNT_W'(PAT_W - 1));
  assign last_data    = (cnt_q == CNT_W'(DATA_W - 1));
  assign last_gap     = (cnt_q == CNT_W'(GAP_CYCLES - 1));
  // Only meaningful for gaps of two or more cycles; a one-cycle gap raises
  // frame_done straight out of DATA instead.
  assign pre_last_gap = (GAP_CYCLES >= 2) && (cnt_q == CNT_W'(GAP_CYCLES - 2));

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; the counter restarts at zero on every phase change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept) state_d = SYNC;
      end
      SYNC: begin
        if (last_sync) begin
          state_d = DATA;
          cnt_d   = '0;
        end
      end
      DATA: begin
        if (last_data) begin
          state_d = GAP;
          cnt_d   = '0;
        end
      end
      GAP: begin
        if (last_gap) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered one step ahead: each value computed here is what
  // the line shows during the next state's cycle.
  always_comb begin
    ser_out_d    = 1'b1;
    tx_active_d  = 1'b0;
    frame_done_d = 1'b0;
    sr_d         = sr_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          // First sync bit goes out directly; the rest is queued pre-shifted.
          ser_out_d   = PATTERN[PAT_W-1];
          tx_active_d = 1'b1;
          sr_d        = {PATTERN, in_if.in_data} << 1;
        end
      end
      SYNC: begin
        ser_out_d   = sr_q[SR_W-1];
        tx_active_d = 1'b1;
        sr_d        = sr_q << 1;
      end
      DATA: begin
        if (!last_data) begin
          ser_out_d   = sr_q[SR_W-1];
          tx_active_d = 1'b1;
          sr_d        = sr_q << 1;
        end else begin
          frame_done_d = (GAP_CYCLES == 1);
        end
      end
      GAP: begin
        frame_done_d = pre_last_gap;
      end
      default: begin
        ser_out_d = 1'b1;
      end
    endcase
  end

  // Output and payload registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q         <= '0;
      ser_out_q    <= 1'b1;
      tx_active_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      sr_q         <= sr_d;
      ser_out_q    <= ser_out_d;
      tx_active_q  <= tx_active_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign ser_out    = ser_out_q;
  assign tx_active  = tx_active_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pattern_frame_transmitter.sv
// Bench for pattern_frame_transmitter: directed vector table, hand-written
// corner sequences and randomized traffic against a frame-level reference model.
module tb_pattern_frame_transmitter;

  localparam int             PAT_W   = 5;
  localparam logic [4:0]     PATTERN = 5'b00110;
  localparam int             DATA_W  = 8;
  localparam int             GAP     = 2;
  localparam int             FLEN    = PAT_W + DATA_W + GAP;

  logic clk = 1'b0;
  logic rst;
  logic ser_out, tx_active, frame_done;

  always #5 clk = ~clk;

  pattern_frame_transmitter_if #(.DATA_W(DATA_W)) bus ();

  pattern_frame_transmitter #(
    .PAT_W      (PAT_W),
    .PATTERN    (PATTERN),
    .DATA_W     (DATA_W),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_if      (bus),
    .ser_out    (ser_out),
    .tx_active  (tx_active),
    .frame_done (frame_done)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: position inside the current frame (-1 = line idle) and the payload.
  int               pos = -1;
  logic [DATA_W-1:0] mdata = '0;
  logic [PAT_W-1:0]  pat_v = PATTERN;
  int               cyc = 0;

  // Sliding window over the line, emulating the downstream recognizer.
  logic [PAT_W-1:0] win = '1;
  int match_cnt = 0;
  int match_cyc = -1;

  // Length of idle runs between tx_active bursts.
  int gap_run  = 0;
  int last_gap = -1;
  bit seen_tx  = 1'b0;

  typedef struct {
    bit         r;
    bit         v;
    logic [7:0] d;
    bit         ser;
    bit         tx;
    bit         done;
    bit         rdy;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit r, bit v, logic [7:0] d, bit ser, bit tx, bit done, bit rdy);
    vec_t e;
    e.r = r; e.v = v; e.d = d; e.ser = ser; e.tx = tx; e.done = done; e.rdy = rdy;
    tbl.push_back(e);
  endfunction

  function automatic logic exp_ser();
    if (pos < 0) return 1'b1;
    if (pos < PAT_W) return pat_v[PAT_W-1-pos];
    if (pos < PAT_W + DATA_W) return mdata[DATA_W-1-(pos-PAT_W)];
    return 1'b1;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Apply inputs, clock one edge, advance the model, sample 1 time unit later.
  task automatic cycle(input bit r, input bit v, input logic [7:0] d);
    rst          = r;
    bus.in_valid = v;
    bus.in_data  = d;
    @(posedge clk);
    if (r) pos = -1;
    else if (pos >= 0) begin
      pos++;
      if (pos == FLEN) pos = -1;
    end else if (v) begin
      pos   = 0;
      mdata = d;
    end
    cyc++;
    #1;
    win = {win[PAT_W-2:0], ser_out};
    if (!r && win == pat_v) begin
      match_cnt++;
      match_cyc = cyc;
    end
    if (tx_active === 1'b1) begin
      if (seen_tx && gap_run > 0) last_gap = gap_run;
      gap_run = 0;
      seen_tx = 1'b1;
    end else begin
      gap_run++;
    end
  endtask

  task automatic check_model();
    chk("ser_out",    int'(ser_out),      int'(exp_ser()));
    chk("tx_active",  int'(tx_active),    int'(pos >= 0 && pos < PAT_W + DATA_W));
    chk("frame_done", int'(frame_done),   int'(pos == FLEN - 1));
    chk("in_ready",   int'(bus.in_ready), int'(pos < 0));
  endtask

  task automatic run(input bit v, input logic [7:0] d, input int n);
    for (int k = 0; k < n; k++) begin
      cycle(1'b0, v, d);
      check_model();
    end
  endtask

  initial begin
    int acc;
    logic [7:0] lb [3];
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    // Reset, idle, then one A5 frame; payload input changes right after accept.
    add(1, 0, 8'h00, 1, 0, 0, 1);
    add(1, 0, 8'h00, 1, 0, 0, 1);
    add(1, 0, 8'h00, 1, 0, 0, 1);
    for (int i = 0; i < 5; i++) add(0, 0, 8'h00, 1, 0, 0, 1);
    add(0, 1, 8'hA5, 0, 1, 0, 0);   // sync bit 4
    add(0, 0, 8'h5A, 0, 1, 0, 0);   // sync bit 3
    add(0, 0, 8'h5A, 1, 1, 0, 0);
    add(0, 0, 8'h5A, 1, 1, 0, 0);
    add(0, 0, 8'h5A, 0, 1, 0, 0);   // sync bit 0
    add(0, 0, 8'h5A, 1, 1, 0, 0);   // A5 bit 7
    add(0, 0, 8'h5A, 0, 1, 0, 0);
    add(0, 0, 8'h5A, 1, 1, 0, 0);
    add(0, 0, 8'h5A, 0, 1, 0, 0);
    add(0, 0, 8'h5A, 0, 1, 0, 0);
    add(0, 0, 8'h5A, 1, 1, 0, 0);
    add(0, 0, 8'h5A, 0, 1, 0, 0);
    add(0, 0, 8'h5A, 1, 1, 0, 0);   // A5 bit 0
    add(0, 0, 8'h5A, 1, 0, 0, 0);   // gap 1
    add(0, 0, 8'h5A, 1, 0, 1, 0);   // gap 2, frame_done
    add(0, 0, 8'h5A, 1, 0, 0, 1);   // idle, ready again

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].r, tbl[i].v, tbl[i].d);
      chk($sformatf("tbl%0d_ser", i),  int'(ser_out),      int'(tbl[i].ser));
      chk($sformatf("tbl%0d_tx", i),   int'(tx_active),    int'(tbl[i].tx));
      chk($sformatf("tbl%0d_done", i), int'(frame_done),   int'(tbl[i].done));
      chk($sformatf("tbl%0d_rdy", i),  int'(bus.in_ready), int'(tbl[i].rdy));
    end

    // Back-to-back: valid held; FF accepted first, then 00 at the next idle cycle.
    run(1'b0, 8'h00, 3);
    seen_tx  = 1'b0;
    gap_run  = 0;
    last_gap = -1;
    cycle(1'b0, 1'b1, 8'hFF);
    check_model();
    run(1'b1, 8'h00, FLEN + 1);
    run(1'b0, 8'h00, FLEN);
    chk("b2b_idle_between", last_gap, GAP + 1);

    // Offer of 3C during the A5 frame is ignored, then sent as its own frame.
    cycle(1'b0, 1'b1, 8'hA5);
    check_model();
    run(1'b1, 8'h3C, FLEN + 1);
    chk("offer_3c_payload", int'(mdata), 8'h3C);
    run(1'b0, 8'h00, FLEN + 2);

    // Reset while the third payload bit is on the line.
    cycle(1'b0, 1'b1, 8'hA5);
    check_model();
    run(1'b0, 8'h00, PAT_W + 2);
    chk("pre_rst_tx", int'(tx_active), 1);
    cycle(1'b1, 1'b0, 8'h00);
    chk("rst_ser", int'(ser_out), 1);
    chk("rst_tx", int'(tx_active), 0);
    chk("rst_done", int'(frame_done), 0);
    run(1'b0, 8'h00, FLEN);

    // Loopback: the sync pattern appears once per frame, ending on the last sync bit.
    lb[0] = 8'hA5; lb[1] = 8'h81; lb[2] = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      match_cnt = 0;
      match_cyc = -1;
      cycle(1'b0, 1'b1, lb[i]);
      acc = cyc;
      check_model();
      run(1'b0, 8'h00, FLEN + 2);
      chk($sformatf("lb%0d_found_cnt", i), match_cnt, 1);
      chk($sformatf("lb%0d_found_cyc", i), match_cyc - acc, PAT_W - 1);
    end

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) == 0), 8'($urandom));
      check_model();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
